// File: rtl/con3_pkg.sv
// Shared definitions for the Pmod CON3 servo driver.
//   ANGLE_W    : width of the angle register written by the UART tester
//   angle_t    : angle type
//   ANGLE_MAX  : full-scale angle (0xFF)
//   state_t    : FSM state type; ST_IDLE / ST_RUN encodings
package con3_pkg;

  localparam int ANGLE_W = 8;
  typedef logic [ANGLE_W-1:0] angle_t;
  localparam angle_t ANGLE_MAX = 8'hFF;

  typedef logic [0:0] state_t;
  localparam state_t ST_IDLE = 1'b0;
  localparam state_t ST_RUN  = 1'b1;

endpackage

// File: rtl/con3_servo_driver_if.sv
// Signal bundle between the servo driver and its user.
//   enable      : run PWM (level)
//   angle       : target angle, may change any cycle
//   servo       : PWM output to the CON3 pin
//   frame_start : one-cycle strobe on the first clk of each frame
//   cur_angle   : angle applied in the current frame
//   settled     : cur_angle matches the angle sampled at the last frame start
//   fsm_state   : debug view of the driver FSM
// Handshake: there is no valid/ready pair. enable and angle are levels the
// driver samples only at frame start; frame_start is the sole output
// qualifier -- cur_angle is valid from the frame_start cycle onward and
// settled from the cycle after it, both holding for the rest of the frame.
interface con3_servo_driver_if;
  import con3_pkg::*;

  logic   enable;
  angle_t angle;
  logic   servo;
  logic   frame_start;
  angle_t cur_angle;
  logic   settled;
  state_t fsm_state;

  modport master (
    output enable, angle,
    input  servo, frame_start, cur_angle, settled, fsm_state
  );

  modport slave (
    input  enable, angle,
    output servo, frame_start, cur_angle, settled, fsm_state
  );

endinterface

// File: rtl/con3_us_tick.sv
// Microsecond prescaler.
//   clk, rst : clock, asynchronous active-high reset
//   run      : count while high; held at zero while low
//   tick     : one-clk pulse when the prescaler wraps (once per microsecond)
// CLK_HZ / 1_000_000 must be an integer >= 2.
module con3_us_tick #(
  parameter int CLK_HZ = 100_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  output logic tick
);

  localparam int DIV = CLK_HZ / 1_000_000;
  localparam int PW  = $clog2(DIV);
  localparam logic [PW-1:0] LAST = PW'(DIV - 1);

  logic [PW-1:0] presc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc <= '0;
    end else if (!run || presc == LAST) begin
      presc <= '0;
    end else begin
      presc <= presc + 1'b1;
    end
  end

  assign tick = run && (presc == LAST);

endmodule

// File: rtl/con3_servo_driver.sv
// Servo PWM generator for one Pmod CON3 channel.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : con3_servo_driver_if.slave (enable, angle in; servo,
//              frame_start, cur_angle, settled, fsm_state out)
// Each frame lasts PERIOD_US microseconds. The pulse is high for
// PULSE_MIN_US plus the number of whole microseconds k with
// k*255 < cur_angle*(PULSE_MAX_US-PULSE_MIN_US). The angle is taken only at
// frame start, so a running pulse is never altered. Dropping enable lets the
// current frame finish before returning to IDLE.
module con3_servo_driver
  import con3_pkg::*;
#(
  parameter int     CLK_HZ       = 100_000_000,
  parameter int     PERIOD_US    = 20000,
  parameter int     PULSE_MIN_US = 1000,
  parameter int     PULSE_MAX_US = 2000,
  parameter int     SLEW_STEP    = 0,
  parameter angle_t INIT_ANGLE   = 8'h80
) (
  input  logic clk,
  input  logic rst,
  con3_servo_driver_if.slave bus
);

  localparam int US_W = $clog2(PERIOD_US);
  localparam int SPAN = PULSE_MAX_US - PULSE_MIN_US;
  // (us - MIN) < 2^US_W and angle*SPAN < 255*PERIOD_US, so both products fit.
  localparam int PROD_W = US_W + ANGLE_W;
  localparam int STEP_W = ANGLE_W + 1;
  localparam int STEP_SAT = (SLEW_STEP > 255) ? 255 : SLEW_STEP;

  localparam logic [US_W-1:0]   US_LAST = US_W'(PERIOD_US - 1);
  localparam logic [PROD_W-1:0] MIN_P   = PROD_W'(PULSE_MIN_US);
  localparam logic [PROD_W-1:0] SPAN_P  = PROD_W'(SPAN);
  localparam logic [PROD_W-1:0] SCALE_P = PROD_W'(ANGLE_MAX);
  localparam logic [STEP_W-1:0] STEP_P  = STEP_W'(STEP_SAT);

  state_t          state;
  logic [US_W-1:0] us_cnt;
  angle_t          cur_angle;
  angle_t          tgt;
  angle_t          next_angle;
  angle_t          up_diff;
  angle_t          dn_diff;
  logic            servo_q;
  logic            fs_q;
  logic            settled_q;
  logic            run;
  logic            tick;
  logic            us_last;
  logic            start_frame;
  logic            pulse_on;
  logic [PROD_W-1:0] us_p;
  logic [PROD_W-1:0] lhs;
  logic [PROD_W-1:0] rhs;

  assign run = (state == ST_RUN);

  con3_us_tick #(.CLK_HZ(CLK_HZ)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .run  (run),
    .tick (tick)
  );

  assign us_last = (us_cnt == US_LAST);
  // A frame starts on leaving IDLE, or at the end-of-frame wrap while enabled.
  assign start_frame = bus.enable && ((state == ST_IDLE) || (tick && us_last));

  // Slew: move toward the target by at most STEP_SAT; since the target lies
  // within 0x00..0xFF, clamping to it also gives the saturation.
  always_comb begin
    next_angle = bus.angle;
    up_diff    = bus.angle - cur_angle;
    dn_diff    = cur_angle - bus.angle;
    if (SLEW_STEP != 0) begin
      if (bus.angle > cur_angle && {1'b0, up_diff} > STEP_P) begin
        next_angle = cur_angle + STEP_P[ANGLE_W-1:0];
      end else if (bus.angle < cur_angle && {1'b0, dn_diff} > STEP_P) begin
        next_angle = cur_angle - STEP_P[ANGLE_W-1:0];
      end
    end
  end

  // Pulse comparator. lhs wraps when us_cnt < MIN, but that case is already
  // covered by the first term.
  always_comb begin
    us_p     = PROD_W'(us_cnt);
    lhs      = (us_p - MIN_P) * SCALE_P;
    rhs      = PROD_W'(cur_angle) * SPAN_P;
    pulse_on = (us_p < MIN_P) || (lhs < rhs);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      us_cnt    <= '0;
      cur_angle <= INIT_ANGLE;
      tgt       <= INIT_ANGLE;
      fs_q      <= 1'b0;
      settled_q <= 1'b0;
      servo_q   <= 1'b0;
    end else begin
      fs_q    <= start_frame;
      servo_q <= run && pulse_on;
      if (fs_q) begin
        settled_q <= (cur_angle == tgt);
      end
      if (start_frame) begin
        tgt       <= bus.angle;
        cur_angle <= next_angle;
      end
      case (state)
        ST_IDLE: begin
          if (bus.enable) begin
            state  <= ST_RUN;
            us_cnt <= '0;
          end
        end
        default: begin
          if (tick) begin
            if (us_last) begin
              us_cnt <= '0;
              if (!bus.enable) begin
                state <= ST_IDLE;
              end
            end else begin
              us_cnt <= us_cnt + 1'b1;
            end
          end
        end
      endcase
    end
  end

  assign bus.servo       = servo_q;
  assign bus.frame_start = fs_q;
  assign bus.cur_angle   = cur_angle;
  assign bus.settled     = settled_q;
  assign bus.fsm_state   = state;

endmodule

// File: tb/tb_con3_servo_driver.sv
// Testbench for con3_servo_driver. Two instances share clk/rst: dut_a with
// no slew limit, dut_b with SLEW_STEP=16. Timing is scaled down so that the
// whole run stays short: 2 MHz clock, 300 us frame, 100..200 us pulse.
module tb_con3_servo_driver;
  import con3_pkg::*;

  localparam int CLK_HZ = 2_000_000;
  localparam int DIV    = CLK_HZ / 1_000_000;
  localparam int PERIOD = 300;
  localparam int PMIN   = 100;
  localparam int PMAX   = 200;
  localparam int FRAME  = PERIOD * DIV;
  localparam int IW     = 26;  // {cur_angle[8], high_clks[16], settled, next_start}

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  initial forever #5 clk = ~clk;

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- DUTs ----------------
  con3_servo_driver_if if_a ();
  con3_servo_driver_if if_b ();

  con3_servo_driver #(
    .CLK_HZ(CLK_HZ), .PERIOD_US(PERIOD), .PULSE_MIN_US(PMIN),
    .PULSE_MAX_US(PMAX), .SLEW_STEP(0), .INIT_ANGLE(8'h80)
  ) dut_a (.clk(clk), .rst(rst), .bus(if_a.slave));

  con3_servo_driver #(
    .CLK_HZ(CLK_HZ), .PERIOD_US(PERIOD), .PULSE_MIN_US(PMIN),
    .PULSE_MAX_US(PMAX), .SLEW_STEP(16), .INIT_ANGLE(8'h80)
  ) dut_b (.clk(clk), .rst(rst), .bus(if_b.slave));

  // Monitor view of whichever instance is under test.
  logic       sel_b;
  logic       m_fs, m_servo, m_settled;
  logic [7:0] m_cur;
  state_t     m_state;
  assign m_fs      = sel_b ? if_b.frame_start : if_a.frame_start;
  assign m_servo   = sel_b ? if_b.servo       : if_a.servo;
  assign m_settled = sel_b ? if_b.settled     : if_a.settled;
  assign m_cur     = sel_b ? if_b.cur_angle   : if_a.cur_angle;
  assign m_state   = sel_b ? if_b.fsm_state   : if_a.fsm_state;

  // ---------------- scoreboard ----------------
  logic [IW-1:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Reference model: pulse length in us is MIN plus the count of k >= 0 with
  // k*255 < a*SPAN, i.e. ceil(a*SPAN/255).
  function automatic int pulse_us(input int a);
    return PMIN + (a * (PMAX - PMIN) + 254) / 255;
  endfunction

  function automatic int slew(input int cur, input int tgt, input int step);
    if (step == 0) return tgt;
    if (tgt - cur > step) return cur + step;
    if (cur - tgt > step) return cur - step;
    return tgt;
  endfunction

  function automatic logic [IW-1:0] pack(input int cur, input int tgt, input bit nxt);
    logic [7:0]  c;
    logic [15:0] h;
    c = cur[7:0];
    h = 16'(pulse_us(cur) * DIV);
    return {c, h, (cur == tgt), nxt};
  endfunction

  int model_cur_a = 128;
  int model_cur_b = 128;

  task automatic push_a(input int ang, input bit nxt);
    model_cur_a = slew(model_cur_a, ang, 0);
    exp_q.push_back(pack(model_cur_a, ang, nxt));
  endtask

  task automatic push_b(input int ang, input bit nxt);
    model_cur_b = slew(model_cur_b, ang, 16);
    exp_q.push_back(pack(model_cur_b, ang, nxt));
  endtask

  task automatic wait_fs(input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (m_fs !== 1'b1 && n < 2 * FRAME);
    check(name, int'(m_fs === 1'b1), 1);
  endtask

  // ---------------- monitor ----------------
  initial begin : monitor
    logic [IW-1:0] e;
    bit         have_e, pending, aborted, extra;
    int         high;
    logic [7:0] cur;
    logic       st, nf;
    pending = 1'b0;
    e = '0;
    forever begin
      if (!pending) begin
        @(negedge clk);
        if (rst !== 1'b0 || m_fs !== 1'b1) continue;
      end
      pending = 1'b0;
      have_e  = (exp_q.size() > 0);
      if (have_e) e = exp_q.pop_front();
      else check("unexpected_frame_start", 1, 0);
      high = 0; aborted = 1'b0; extra = 1'b0; cur = m_cur;
      for (int off = 0; off < FRAME; off++) begin
        if (off > 0) begin
          @(negedge clk);
          if (m_fs) extra = 1'b1;
        end
        if (rst) begin
          aborted = 1'b1;
          break;
        end
        if (m_servo) high++;
      end
      if (aborted) continue;
      st = m_settled;
      @(negedge clk);
      nf = m_fs && !rst;
      if (have_e) begin
        check("frame_cur_angle", int'(cur), int'(e[25:18]));
        check("frame_high_clks", high, int'(e[17:2]));
        check("frame_settled", int'(st), int'(e[1]));
        check("frame_next_start", int'(nf), int'(e[0]));
      end
      check("no_mid_frame_start", int'(extra), 0);
      pending = nf;
    end
  end

  // ---------------- driver ----------------
  initial begin : driver
    logic [7:0] tbl [4];
    int fs_seen, hi_seen, a;
    sel_b = 1'b0;
    if_a.enable = 1'b0; if_a.angle = 8'h00;
    if_b.enable = 1'b0; if_b.angle = 8'h00;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_servo", int'(m_servo), 0);
    check("rst_frame_start", int'(m_fs), 0);
    check("rst_cur_angle", int'(m_cur), 128);
    check("rst_settled", int'(m_settled), 0);
    check("rst_state", int'(m_state), int'(ST_IDLE));
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check("idle_no_start", int'(m_fs), 0);

    // angle 0x00, then 0xFF, then 0x80
    push_a(8'h00, 1'b1);
    if_a.enable = 1'b1;
    wait_fs("start_f1");
    push_a(8'h00, 1'b1);
    wait_fs("start_f2");
    repeat (20) @(negedge clk);
    if_a.angle = 8'hFF; push_a(8'hFF, 1'b1);
    wait_fs("start_ff");
    repeat (20) @(negedge clk);
    if_a.angle = 8'h80; push_a(8'h80, 1'b1);
    wait_fs("start_80");
    repeat (20) @(negedge clk);
    if_a.angle = 8'h00; push_a(8'h00, 1'b1);
    // angle moves to 0xFF 50 us into a 0x00 frame: only the next frame sees it
    wait_fs("start_00");
    repeat (100) @(negedge clk);
    if_a.angle = 8'hFF; push_a(8'hFF, 1'b1);
    wait_fs("start_late_ff");

    // boundary table then random angles, with a throwaway mid-frame value
    tbl = '{8'h01, 8'hFE, 8'h7F, 8'h00};
    for (int i = 0; i < 8; i++) begin
      repeat ($urandom_range(5, FRAME / 2)) @(negedge clk);
      if_a.angle = 8'($urandom_range(0, 255));
      repeat ($urandom_range(1, 20)) @(negedge clk);
      a = (i < 4) ? int'(tbl[i]) : int'($urandom_range(0, 255));
      if_a.angle = 8'(a);
      push_a(a, 1'b1);
      wait_fs("start_rand");
    end

    // enable dropped and restored within a frame: no restart, no gap
    repeat (50) @(negedge clk);
    if_a.enable = 1'b0;
    repeat (100) @(negedge clk);
    if_a.enable = 1'b1;
    if_a.angle = 8'h40; push_a(8'h40, 1'b1);
    wait_fs("start_keep_running");

    // enable low at 120 us into a 0xFF frame: pulse completes, then idle
    if_a.angle = 8'hFF; push_a(8'hFF, 1'b0);
    wait_fs("start_before_disable");
    repeat (240) @(negedge clk);
    if_a.enable = 1'b0;
    if_a.angle = 8'h00;
    repeat (FRAME - 240 + 4) @(negedge clk);
    fs_seen = 0; hi_seen = 0;
    repeat (2 * FRAME) begin
      @(negedge clk);
      if (m_fs) fs_seen++;
      if (m_servo) hi_seen++;
    end
    check("idle_frame_starts", fs_seen, 0);
    check("idle_servo_high", hi_seen, 0);
    check("idle_state", int'(m_state), int'(ST_IDLE));
    check("idle_cur_hold", int'(m_cur), 255);

    // re-enable: frame_start on the next clk
    if_a.angle = 8'h10; push_a(8'h10, 1'b1);
    if_a.enable = 1'b1;
    @(negedge clk);
    check("reenable_start", int'(m_fs), 1);

    // reset 50 us into the pulse
    repeat (100) @(negedge clk);
    check("pulse_before_rst", int'(m_servo), 1);
    rst = 1'b1;
    #1;
    check("rst_mid_servo", int'(m_servo), 0);
    check("rst_mid_cur_angle", int'(m_cur), 128);
    check("rst_mid_settled", int'(m_settled), 0);
    check("rst_mid_state", int'(m_state), int'(ST_IDLE));
    exp_q.delete();
    model_cur_a = 128;
    if_a.enable = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    fs_seen = 0;
    repeat (50) begin
      @(negedge clk);
      if (m_fs) fs_seen++;
    end
    check("post_rst_no_start", fs_seen, 0);
    check("post_rst_state", int'(m_state), int'(ST_IDLE));

    // slew-limited instance: 0x80 -> 0xFF in steps of 16
    sel_b = 1'b1;
    @(negedge clk);
    check("b_init_cur", int'(m_cur), 128);
    if_b.angle = 8'hFF;
    for (int k = 0; k < 9; k++) push_b(8'hFF, k < 8);
    if_b.enable = 1'b1;
    for (int k = 0; k < 9; k++) wait_fs("b_start");
    if_b.enable = 1'b0;
    repeat (FRAME + 5) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
